// File: rtl/dmem_bus_ctrl_pkg.sv
// dmem_bus_ctrl_pkg: FSM state encodings and abort data for the data-memory bus controller
package dmem_bus_ctrl_pkg;
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/dmem_bus_ctrl_watchdog.sv
// dmem_watchdog: counts BUSY cycles without acknowledge and flags expiry
module dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [TO_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + TO_W'(1);
  // expiry is the cycle whose increment would make the count reach the limit
  assign expired = inc && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: MEM-stage load/store to single-word cyc/stb/ack bus with pipeline stall.
// Optional bus timeout abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        ram_cs,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        ram_stall,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic        bus_err
);
  dmem_state_e state_q;
  logic        cyc_q, we_q, err_q, req, expired;
  logic [31:0] addr_q, dout_q, rdata_q;
  logic        unused_addr_lsb;
  if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end
  assign unused_addr_lsb = ^mem_addr[1:0];
  assign req = mem_valid && ram_cs && (mem_ren || mem_wen);
`ifdef DMEM_TIMEOUT_EN
  dmem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == DMEM_IDLE && req),
    .inc     (state_q == DMEM_BUSY && !bus_ack),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= DMEM_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        DMEM_IDLE: if (req) begin
          state_q <= DMEM_BUSY;
          cyc_q   <= 1'b1;
          we_q    <= mem_wen;
          addr_q  <= {mem_addr[31:2], 2'b00};
          dout_q  <= mem_wdata;
        end
        DMEM_BUSY: if (bus_ack || expired) begin
          state_q <= DMEM_DONE;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          err_q   <= !bus_ack;
          if (!we_q) rdata_q <= bus_ack ? bus_din : DMEM_ERR_DATA;
        end
        default: begin
          state_q <= DMEM_IDLE;
          err_q   <= 1'b0;
        end
      endcase
    end
  // stall rises combinationally with the request so the pipeline freezes that cycle
  assign ram_stall = !rst && (state_q == DMEM_BUSY || (state_q == DMEM_IDLE && req));
  assign bus_cyc   = cyc_q;
  assign bus_stb   = cyc_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_dout  = dout_q;
  assign mem_rdata = rdata_q;
  assign bus_err   = err_q;
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl: directed transaction bench with per-cycle expected-value compare
module tb_dmem_bus_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_valid = 0, ram_cs = 0, mem_ren = 0, mem_wen = 0, bus_ack = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, bus_din = 0;
  logic [31:0] mem_rdata, bus_addr, bus_dout;
  logic        ram_stall, bus_cyc, bus_stb, bus_we, bus_err;
  int          tests = 0, fails = 0, stall_cnt = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall = 0, exp_cyc = 0, exp_we = 0, exp_err = 0;
  logic [31:0] exp_addr = 0, exp_dout = 0, exp_rdata = 0, addr_seen = 0;
  logic        we_seen = 0;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .ram_cs(ram_cs), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ram_stall(ram_stall), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("ram_stall", 32'(ram_stall), 32'(exp_stall));
    chk("bus_cyc", 32'(bus_cyc), 32'(exp_cyc));
    chk("bus_stb", 32'(bus_stb), 32'(exp_cyc));
    chk("bus_we", 32'(bus_we), 32'(exp_cyc & exp_we));
    chk("bus_err", 32'(bus_err), 32'(exp_err));
    chk("mem_rdata", mem_rdata, exp_rdata);
    if (exp_cyc) begin
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_dout", bus_dout, exp_dout);
    end
  end

  task automatic step();
    @(negedge clk);
    stall_cnt += int'(ram_stall);
    if (bus_cyc) begin
      addr_seen = bus_addr;
      we_seen   = bus_we;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ack);
    bus_ack = ack;
    exp_stall = 0;
    exp_cyc = 0;
    for (int i = 0; i < n; i++) begin
      bus_din = $urandom;
      step();
    end
    bus_ack = 0;
  endtask

  // request cycle, (w+1) bus cycles with ack on the last, then the completion cycle
  task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] din, input int w);
    mem_valid = 1; ram_cs = 1; mem_ren = ren; mem_wen = wen; mem_addr = a; mem_wdata = wd;
    exp_stall = 1; exp_cyc = 0; exp_we = wen; exp_addr = a & 32'hFFFF_FFFC; exp_dout = wd;
    stall_cnt = 0;
    step();
    for (int i = 0; i <= w; i++) begin
      bus_ack = (i == w);
      bus_din = (i == w) ? din : 32'hBAD0_0000 + 32'(i);
      exp_cyc = 1;
      step();
    end
    bus_ack = 0;
    exp_cyc = 0;
    exp_stall = 0;
    if (!wen) exp_rdata = din;
    step();
    mem_valid = 0; ram_cs = 0; mem_ren = 0; mem_wen = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1; ram_cs = 1; mem_ren = 1; bus_ack = 1;
    #1;
    chk("rst_stall", 32'(ram_stall), 0);
    chk("rst_cyc", 32'(bus_cyc), 0);
    chk("rst_stb", 32'(bus_stb), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_dout", bus_dout, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_err", 32'(bus_err), 0);
    mem_valid = 0; ram_cs = 0; mem_ren = 0; bus_ack = 0;
    @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    idle(2, 0);
    access(1, 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0);
    chk("t1_stalls", 32'(stall_cnt), 2);
    chk("t1_we", 32'(we_seen), 0);
    chk("t1_rdata", mem_rdata, 32'h1234_5678);
    idle(1, 0);
    access(0, 1, 32'h0000_0023, 32'hCAFE_0001, 32'h5555_AAAA, 4);
    chk("t2_stalls", 32'(stall_cnt), 6);
    chk("t2_addr", addr_seen, 32'h0000_0020);
    chk("t2_we", 32'(we_seen), 1);
    chk("t2_rdata", mem_rdata, 32'h1234_5678);
    idle(1, 0);
    access(1, 0, 32'h0000_0100, 32'h0, 32'h1111_1111, 0);
    access(1, 0, 32'h0000_0106, 32'h0, 32'h2222_2222, 1);
    chk("b2b_stalls", 32'(stall_cnt), 3);
    chk("b2b_rdata", mem_rdata, 32'h2222_2222);
    access(1, 1, 32'h0000_0200, 32'hA5A5_0F0F, 32'h9999_9999, 2);
    chk("prio_we", 32'(we_seen), 1);
    chk("prio_rdata", mem_rdata, 32'h2222_2222);
    mem_valid = 0; ram_cs = 1; mem_ren = 1;
    idle(3, 1);
    chk("novalid_rdata", mem_rdata, 32'h2222_2222);
    ram_cs = 0; mem_ren = 0;
    mem_valid = 1; ram_cs = 1; mem_ren = 1; mem_addr = 32'h80;
    exp_stall = 1; exp_cyc = 0; exp_we = 0; exp_addr = 32'h80; exp_dout = mem_wdata;
    step();
    exp_cyc = 1;
    bus_ack = 0;
    step();
    chk_en = 0;
    #1 rst = 1;
    #1;
    chk("rst_busy_cyc", 32'(bus_cyc), 0);
    chk("rst_busy_stb", 32'(bus_stb), 0);
    chk("rst_busy_stall", 32'(ram_stall), 0);
    chk("rst_busy_rdata", mem_rdata, 0);
    mem_valid = 0; ram_cs = 0; mem_ren = 0;
    @(posedge clk);
    #1;
    rst = 0;
    exp_rdata = 0; exp_stall = 0; exp_cyc = 0;
    chk_en = 1;
    idle(2, 0);
    access(1, 0, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 1);
    chk("post_rst_rdata", mem_rdata, 32'h0BAD_F00D);
`ifdef DMEM_TIMEOUT_EN
    idle(1, 0);
    mem_valid = 1; ram_cs = 1; mem_ren = 1; mem_addr = 32'h44;
    exp_stall = 1; exp_cyc = 0; exp_we = 0; exp_addr = 32'h44; exp_dout = mem_wdata;
    stall_cnt = 0;
    step();
    exp_cyc = 1;
    repeat (4) step();
    exp_cyc = 0; exp_stall = 0; exp_err = 1; exp_rdata = 32'hDEAD_BEEF;
    step();
    mem_valid = 0; ram_cs = 0; mem_ren = 0;
    exp_err = 0;
    idle(2, 0);
    chk("to_stalls", 32'(stall_cnt), 5);
    chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
`endif
    idle(2, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
